// File: rtl/audio_sample_fifo.sv
// Sample FIFO and fixed-rate pacer that feeds the PWM DAC; outputs MIDSCALE while not playing.
// Optional underrun counter port enabled by defining AUDIO_FIFO_UNDERRUN_CNT_EN.
module audio_sample_fifo #(
    parameter int          F_CLK       = 100_000_000,
    parameter int          F_SAMPLE    = 44100,
    parameter int          DEPTH_LOG2  = 9,
    parameter int          PRIME_LEVEL = 256,
    parameter logic [15:0] MIDSCALE    = 16'h8000
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  enable_i,
    input  logic                  flush_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [15:0]           s_data_i,
    output logic [15:0]           data_o,
    output logic                  sample_tick_o,
    output logic                  playing_o,
    output logic                  underrun_o,
    output logic [DEPTH_LOG2:0]   level_o
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    ,
    output logic [15:0]           underrun_cnt_o
`endif
);

    localparam int PERIOD = F_CLK / F_SAMPLE;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int LW     = DEPTH_LOG2 + 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [LW-1:0]    LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0]    LVL_PRIME = LW'(PRIME_LEVEL);

    typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [15:0]             mem [DEPTH];

    logic wrap;
    logic push;
    logic pop;
    logic underrun_ev;

    assign wrap        = (cnt == CNT_LAST);
    assign s_ready_o   = (level_o != LVL_FULL) && !flush_i;
    assign push        = s_valid_i && s_ready_o;
    assign pop         = (state == PLAY) && enable_i && wrap && (level_o != '0) && !flush_i;
    assign underrun_ev = (state == PLAY) && enable_i && wrap && (level_o == '0) && !flush_i;

    // Sample storage carries no reset; only pointers and level define its contents.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= s_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cnt           <= '0;
            sample_tick_o <= 1'b0;
            underrun_o    <= 1'b0;
            playing_o     <= 1'b0;
            state         <= IDLE;
            data_o        <= MIDSCALE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level_o       <= '0;
        end else begin
            // The pacer never stops, so the sample period is unaffected by state, enable or flush.
            cnt           <= wrap ? '0 : cnt + CNT_W'(1);
            sample_tick_o <= wrap;
            underrun_o    <= 1'b0;

            if (flush_i) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level_o   <= '0;
                state     <= IDLE;
                playing_o <= 1'b0;
                data_o    <= MIDSCALE;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   level_o <= level_o + LW'(1);
                    2'b01:   level_o <= level_o - LW'(1);
                    default: level_o <= level_o;
                endcase

                if (!enable_i) begin
                    state     <= IDLE;
                    playing_o <= 1'b0;
                    data_o    <= MIDSCALE;
                end else begin
                    case (state)
                        IDLE: begin
                            state <= PRIME;
                        end
                        PRIME: begin
                            if (level_o >= LVL_PRIME) begin
                                state     <= PLAY;
                                playing_o <= 1'b1;
                            end
                        end
                        PLAY: begin
                            if (pop) begin
                                data_o <= mem[rd_ptr];
                            end else if (underrun_ev) begin
                                data_o     <= MIDSCALE;
                                underrun_o <= 1'b1;
                                state      <= PRIME;
                                playing_o  <= 1'b0;
                            end
                        end
                        default: begin
                            state     <= IDLE;
                            playing_o <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            underrun_cnt_o <= '0;
        end else if (flush_i) begin
            underrun_cnt_o <= '0;
        end else if (underrun_ev) begin
            underrun_cnt_o <= sat_inc(underrun_cnt_o);
        end
    end
`endif

endmodule
